// File: rtl/bn_res_act_stage.sv
// Per-lane batch-norm scale/bias, optional residual add, ReLU and saturation on an
// MVM accumulator stream. Three-stage pipeline with a single global stall (adv).
module bn_res_act_stage #(
  parameter int TOUT    = 8,
  parameter int ACC_DW  = 32,
  parameter int DAT_DW  = 16,
  parameter int BN_DW   = 16,
  parameter int MAX_GRP = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                cfg_ch_grp,
  input  logic [15:0]                cfg_pix,
  input  logic                       cfg_relu_en,
  input  logic                       cfg_res_en,
  input  logic [4:0]                 cfg_wt_sh,
  input  logic [4:0]                 cfg_bias_sh,
  input  logic [4:0]                 cfg_res_sh,
  input  logic [4:0]                 cfg_out_sh,
  input  logic                       bn_wr_en,
  input  logic [$clog2(MAX_GRP)-1:0] bn_wr_addr,
  input  logic [2*BN_DW*TOUT-1:0]    bn_wr_data,
  input  logic                       acc_valid,
  output logic                       acc_ready,
  input  logic [ACC_DW*TOUT-1:0]     acc_data,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [DAT_DW*TOUT-1:0]     res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DAT_DW*TOUT-1:0]     out_data,
  output logic                       busy,
  output logic                       done
);

  localparam int AW  = $clog2(MAX_GRP);
  localparam int BNW = 2*BN_DW*TOUT;
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DAT_DW-1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DAT_DW-1));

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic signed [63:0] sext_acc(input logic [ACC_DW-1:0] v);
    return {{(64-ACC_DW){v[ACC_DW-1]}}, v};
  endfunction

  function automatic logic signed [63:0] sext_bn(input logic [BN_DW-1:0] v);
    return {{(64-BN_DW){v[BN_DW-1]}}, v};
  endfunction

  function automatic logic signed [63:0] sext_dat(input logic [DAT_DW-1:0] v);
    return {{(64-DAT_DW){v[DAT_DW-1]}}, v};
  endfunction

  function automatic logic [DAT_DW-1:0] act_sat(input logic signed [63:0] r, input logic relu);
    if (relu && (r < 64'sd0)) return {DAT_DW{1'b0}};
    else if (r > SAT_MAX)     return SAT_MAX[DAT_DW-1:0];
    else if (r < SAT_MIN)     return SAT_MIN[DAT_DW-1:0];
    else                      return r[DAT_DW-1:0];
  endfunction

  state_t            state_r;
  logic [15:0]       ch_grp_r, pix_r, pix_cnt_r, grp_cnt_r;
  logic              relu_en_r, res_en_r, busy_r, done_r;
  logic [4:0]        wt_sh_r, bias_sh_r, res_sh_r, out_sh_r;
  logic [BNW-1:0]    bn_mem_r [MAX_GRP];

  logic                       s1_valid_r, s2_valid_r, s3_valid_r;
  logic [ACC_DW*TOUT-1:0]     s1_acc_r;
  logic [DAT_DW*TOUT-1:0]     s1_res_r, s2_res_r, out_data_r;
  logic [BNW-1:0]             s1_bn_r;
  logic [BN_DW*TOUT-1:0]      s2_bias_r;
  logic signed [63:0]         s2_p_r [TOUT];

  logic                       adv_s, accept_s, last_beat_s, pipe_empty_s;
  logic signed [63:0]         p_s [TOUT];
  logic signed [63:0]         t_s [TOUT];
  logic [DAT_DW*TOUT-1:0]     r_vec_s;

  assign adv_s        = ~(s3_valid_r & ~out_ready);
  assign acc_ready    = (state_r == RUN) & adv_s & (res_valid | ~res_en_r);
  assign res_ready    = (state_r == RUN) & adv_s & acc_valid & res_en_r;
  assign accept_s     = acc_ready & acc_valid;
  assign last_beat_s  = (pix_cnt_r == pix_r - 16'd1) && (grp_cnt_r == ch_grp_r - 16'd1);
  assign pipe_empty_s = ~(s1_valid_r | s2_valid_r | s3_valid_r);
  assign out_valid    = s3_valid_r;
  assign out_data     = out_data_r;
  assign busy         = busy_r;
  assign done         = done_r;

  // Layer sequencing: config capture, beat counters, busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ch_grp_r  <= 16'd0;
      pix_r     <= 16'd0;
      pix_cnt_r <= 16'd0;
      grp_cnt_r <= 16'd0;
      relu_en_r <= 1'b0;
      res_en_r  <= 1'b0;
      wt_sh_r   <= 5'd0;
      bias_sh_r <= 5'd0;
      res_sh_r  <= 5'd0;
      out_sh_r  <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= RUN;
            busy_r    <= 1'b1;
            ch_grp_r  <= cfg_ch_grp;
            pix_r     <= cfg_pix;
            relu_en_r <= cfg_relu_en;
            res_en_r  <= cfg_res_en;
            wt_sh_r   <= cfg_wt_sh;
            bias_sh_r <= cfg_bias_sh;
            res_sh_r  <= cfg_res_sh;
            out_sh_r  <= cfg_out_sh;
            pix_cnt_r <= 16'd0;
            grp_cnt_r <= 16'd0;
          end
        end
        RUN: begin
          if (accept_s) begin
            if (last_beat_s) begin
              state_r   <= DRAIN;
              pix_cnt_r <= 16'd0;
            end else if (pix_cnt_r == pix_r - 16'd1) begin
              pix_cnt_r <= 16'd0;
              grp_cnt_r <= grp_cnt_r + 16'd1;
            end else begin
              pix_cnt_r <= pix_cnt_r + 16'd1;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // BN parameter buffer: no reset so parameters survive a layer abort.
  always_ff @(posedge clk) begin
    if (bn_wr_en) begin
      bn_mem_r[bn_wr_addr] <= bn_wr_data;
    end
  end

  // Stage 2 datapath: scaled product per lane.
  always_comb begin
    for (int k = 0; k < TOUT; k++) begin
      p_s[k] = (sext_acc(s1_acc_r[k*ACC_DW +: ACC_DW]) *
                sext_bn(s1_bn_r[2*BN_DW*k +: BN_DW])) >>> wt_sh_r;
    end
  end

  // Stage 3 datapath: bias, residual, output shift, ReLU and saturation.
  always_comb begin
    r_vec_s = {(DAT_DW*TOUT){1'b0}};
    for (int k = 0; k < TOUT; k++) begin
      t_s[k] = s2_p_r[k] + (sext_bn(s2_bias_r[k*BN_DW +: BN_DW]) <<< bias_sh_r) +
               (res_en_r ? (sext_dat(s2_res_r[k*DAT_DW +: DAT_DW]) <<< res_sh_r) : 64'sd0);
      r_vec_s[k*DAT_DW +: DAT_DW] = act_sat(t_s[k] >>> out_sh_r, relu_en_r);
    end
  end

  // Pipeline registers; every stage holds while the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s3_valid_r <= 1'b0;
      s1_acc_r   <= {(ACC_DW*TOUT){1'b0}};
      s1_res_r   <= {(DAT_DW*TOUT){1'b0}};
      s1_bn_r    <= {BNW{1'b0}};
      s2_res_r   <= {(DAT_DW*TOUT){1'b0}};
      s2_bias_r  <= {(BN_DW*TOUT){1'b0}};
      out_data_r <= {(DAT_DW*TOUT){1'b0}};
      for (int k = 0; k < TOUT; k++) s2_p_r[k] <= 64'sd0;
    end else if (adv_s) begin
      s1_valid_r <= accept_s;
      s2_valid_r <= s1_valid_r;
      s3_valid_r <= s2_valid_r;
      if (accept_s) begin
        s1_acc_r <= acc_data;
        s1_res_r <= res_data;
        s1_bn_r  <= bn_mem_r[grp_cnt_r[AW-1:0]];
      end
      if (s1_valid_r) begin
        s2_res_r <= s1_res_r;
        for (int k = 0; k < TOUT; k++) begin
          s2_p_r[k] <= p_s[k];
          s2_bias_r[k*BN_DW +: BN_DW] <= s1_bn_r[2*BN_DW*k + BN_DW +: BN_DW];
        end
      end
      if (s2_valid_r) begin
        out_data_r <= r_vec_s;
      end
    end
  end

endmodule

// File: tb/tb_bn_res_act_stage.sv
// Directed bench for bn_res_act_stage: literal expectations for the fixed vectors and a
// spec-level arithmetic model for the stalled/skewed and reset-abort layers.
module tb_bn_res_act_stage;
  localparam int TOUT = 8, ACC_DW = 32, DAT_DW = 16, BN_DW = 16, MAX_GRP = 64;

  logic clk, rst, start;
  logic [15:0] c_grp, c_pix;
  logic c_relu, c_res_en;
  logic [4:0] c_wt_sh, c_bias_sh, c_res_sh, c_out_sh;
  logic bn_wr_en;
  logic [5:0] bn_wr_addr;
  logic [2*BN_DW*TOUT-1:0] bn_wr_data;
  logic acc_valid, acc_ready, res_valid, res_ready, out_valid, out_ready, busy, done;
  logic [ACC_DW*TOUT-1:0] acc_data;
  logic [DAT_DW*TOUT-1:0] res_data, out_data;

  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;
  int first_acc_cyc = 0, last_acc_cyc = 0;
  bit lat_en = 0, rand_out = 0, res_rdy_seen = 0, hold_pending = 0;
  logic [127:0] held_data;
  int bn_w [64][8];
  int bn_b [64][8];
  logic [255:0] acc_q[$];
  logic [127:0] res_q[$];
  logic [127:0] exp_q[$];
  int lat_q[$];

  bn_res_act_stage #(.TOUT(TOUT), .ACC_DW(ACC_DW), .DAT_DW(DAT_DW), .BN_DW(BN_DW),
                     .MAX_GRP(MAX_GRP)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_ch_grp(c_grp), .cfg_pix(c_pix),
    .cfg_relu_en(c_relu), .cfg_res_en(c_res_en), .cfg_wt_sh(c_wt_sh),
    .cfg_bias_sh(c_bias_sh), .cfg_res_sh(c_res_sh), .cfg_out_sh(c_out_sh),
    .bn_wr_en(bn_wr_en), .bn_wr_addr(bn_wr_addr), .bn_wr_data(bn_wr_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial begin forever begin @(posedge clk); cyc++; end end
  initial begin #2000000; $display("FAIL watchdog: time limit reached"); $fatal(1); end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec-level arithmetic for one lane.
  function automatic logic [15:0] model(input longint acc, input longint w, input longint b,
                                        input longint res);
    longint p, t, r;
    p = (acc * w) >>> c_wt_sh;
    t = p + (b <<< c_bias_sh) + (c_res_en ? (res <<< c_res_sh) : 64'sd0);
    r = t >>> c_out_sh;
    if (c_relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Output monitor: order, content, stability under stall, latency, done/res_ready events.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (res_ready) res_rdy_seen = 1'b1;
        if (hold_pending) begin
          chk("out_hold_valid", out_valid, 1'b1);
          chk("out_hold_data", out_data, held_data);
        end
        hold_pending = out_valid && !out_ready;
        held_data = out_data;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL spurious_out: got %h with no beat expected", out_data);
          end else begin
            chk("out_data", out_data, exp_q.pop_front());
          end
          if (lat_en && lat_q.size() > 0) chk("latency", cyc - lat_q.pop_front(), 3);
        end
      end
    end
  end

  task automatic bn_write(input int addr, input int w0, input int wstep, input int b0);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) begin
      bn_w[addr][k] = w0 + k*wstep;
      bn_b[addr][k] = b0;
      d[k*32 +: 16]      = 16'(w0 + k*wstep);
      d[k*32 + 16 +: 16] = 16'(b0);
    end
    bn_wr_en = 1'b1; bn_wr_addr = 6'(addr); bn_wr_data = d;
    @(posedge clk); #1;
    bn_wr_en = 1'b0;
  endtask

  task automatic drive_acc(input int n, input int skew);
    for (int i = 0; i < n; i++) begin
      int d, guard;
      bit hs;
      d = (skew > 0) ? int'($urandom_range(0, skew)) : 0;
      repeat (d) begin @(posedge clk); #1; end
      acc_data = acc_q.pop_front(); acc_valid = 1'b1; hs = 1'b0; guard = 0;
      while (!hs && guard < 300) begin
        @(negedge clk);
        hs = acc_ready;
        if (hs) begin
          if (i == 0) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
          if (lat_en) lat_q.push_back(cyc);
        end
        @(posedge clk); #1;
        guard++;
      end
      acc_valid = 1'b0;
      if (!hs) chk("acc_handshake_timeout", hs, 1'b1);
    end
  endtask

  task automatic drive_res(input int n, input int skew);
    for (int i = 0; i < n; i++) begin
      int d, guard;
      bit hs;
      d = (skew > 0) ? int'($urandom_range(0, skew)) : 0;
      repeat (d) begin @(posedge clk); #1; end
      res_data = res_q.pop_front(); res_valid = 1'b1; hs = 1'b0; guard = 0;
      while (!hs && guard < 300) begin
        @(negedge clk);
        hs = res_ready;
        @(posedge clk); #1;
        guard++;
      end
      res_valid = 1'b0;
      if (!hs) chk("res_handshake_timeout", hs, 1'b1);
    end
  endtask

  task automatic start_layer();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_run", busy, 1'b1);
  endtask

  task automatic run_layer(input int n, input int skew, input int budget);
    int d0, g;
    bit seen;
    d0 = done_cnt; res_rdy_seen = 1'b0; g = 0; seen = 1'b0;
    start_layer();
    fork
      drive_acc(n, skew);
      if (c_res_en) drive_res(n, skew);
    join
    while (!seen && g < budget) begin @(negedge clk); seen = done; g++; end
    chk("done_seen", seen, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("busy_idle", busy, 1'b0);
    chk("done_once", done_cnt - d0, 1);
    chk("exp_drained", exp_q.size(), 0);
    if (!c_res_en) chk("res_ready_low", res_rdy_seen, 1'b0);
  endtask

  task automatic gen_model(input int grp, input int pix, input int n_exp);
    logic [255:0] av;
    logic [127:0] rv, ev;
    int i, a, r;
    acc_q.delete(); res_q.delete(); exp_q.delete();
    i = 0;
    for (int g = 0; g < grp; g++) begin
      for (int p = 0; p < pix; p++) begin
        for (int k = 0; k < 8; k++) begin
          a = i*1000 - k*700 + 123;
          r = k*50 - i*30 - 100;
          av[k*32 +: 32] = 32'(a);
          rv[k*16 +: 16] = 16'(r);
          ev[k*16 +: 16] = model(a, bn_w[g % 64][k], bn_b[g % 64][k], r);
        end
        acc_q.push_back(av); res_q.push_back(rv);
        if (i < n_exp) exp_q.push_back(ev);
        i++;
      end
    end
  endtask

  task automatic set_cfg(input int grp, input int pix, input bit relu, input bit res_en,
                         input int wsh, input int bsh, input int rsh, input int osh);
    c_grp = 16'(grp); c_pix = 16'(pix); c_relu = relu; c_res_en = res_en;
    c_wt_sh = 5'(wsh); c_bias_sh = 5'(bsh); c_res_sh = 5'(rsh); c_out_sh = 5'(osh);
  endtask

  initial begin
    logic [255:0] av;
    logic [127:0] rv, ev;
    int d0;
    rst = 1'b1; start = 1'b0; bn_wr_en = 1'b0; bn_wr_addr = '0; bn_wr_data = '0;
    acc_valid = 1'b1; res_valid = 1'b1; acc_data = '0; res_data = '0;
    set_cfg(1, 1, 0, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_acc_ready", acc_ready, 1'b0);
    chk("rst_res_ready", res_ready, 1'b0);
    chk("rst_out_data", out_data, 128'd0);
    acc_valid = 1'b0; res_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 64; a++) bn_write(a, 1, 0, 0);

    // Identity pass-through over 68 groups with full throughput and 3-cycle latency.
    set_cfg(68, 1, 0, 0, 0, 0, 0, 0);
    acc_q.delete(); exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      av[k*32 +: 32] = 32'(k - 3);
      ev[k*16 +: 16] = 16'(k - 3);
    end
    for (int i = 0; i < 68; i++) begin acc_q.push_back(av); exp_q.push_back(ev); end
    lat_q.delete(); lat_en = 1'b1;
    run_layer(68, 0, 1000);
    lat_en = 1'b0;
    chk("throughput", last_acc_cyc - first_acc_cyc, 67);

    // (10*3>>>1) + (2<<<2) - 4 = 19, >>>1 = 9
    bn_write(0, 3, 0, 2);
    set_cfg(1, 1, 0, 1, 1, 2, 0, 1);
    chk("model_pin_9", model(10, 3, 2, -4), 16'd9);
    acc_q.delete(); res_q.delete(); exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      av[k*32 +: 32] = 32'd10; rv[k*16 +: 16] = 16'hfffc; ev[k*16 +: 16] = 16'd9;
    end
    acc_q.push_back(av); res_q.push_back(rv); exp_q.push_back(ev);
    run_layer(1, 0, 200);

    // Saturation both ways with w=4 (lane 0 of beat 1 stays in range: 100*4=400).
    bn_write(0, 4, 0, 0);
    set_cfg(1, 2, 0, 0, 0, 0, 0, 0);
    chk("model_pin_satp", model(40000, 4, 0, 0), 16'h7fff);
    chk("model_pin_satn", model(-40000, 4, 0, 0), 16'h8000);
    acc_q.delete(); exp_q.delete();
    for (int k = 0; k < 8; k++) begin av[k*32 +: 32] = 32'd40000; ev[k*16 +: 16] = 16'h7fff; end
    acc_q.push_back(av); exp_q.push_back(ev);
    for (int k = 0; k < 8; k++) begin av[k*32 +: 32] = -32'sd40000; ev[k*16 +: 16] = 16'h8000; end
    av[31:0] = 32'd100; ev[15:0] = 16'd400;
    acc_q.push_back(av); exp_q.push_back(ev);
    run_layer(2, 0, 200);

    // ReLU: negative lanes clamp to 0, positive lanes pass.
    bn_write(0, 1, 0, 0);
    set_cfg(1, 1, 1, 0, 0, 0, 0, 0);
    chk("model_pin_relu", model(-100, 1, 0, 0), 16'd0);
    acc_q.delete(); exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      av[k*32 +: 32] = (k % 2 == 0) ? -32'sd100 : 32'sd50;
      ev[k*16 +: 16] = (k % 2 == 0) ? 16'd0 : 16'd50;
    end
    acc_q.push_back(av); exp_q.push_back(ev);
    run_layer(1, 0, 200);

    // Skewed inputs and random backpressure, with and without residual.
    bn_write(0, 2, 1, -3);
    bn_write(1, -1, -1, 5);
    rand_out = 1'b1;
    set_cfg(2, 3, 1, 1, 1, 1, 1, 2);
    gen_model(2, 3, 6);
    run_layer(6, 5, 2000);
    set_cfg(2, 3, 0, 0, 1, 1, 1, 2);
    gen_model(2, 3, 6);
    run_layer(6, 5, 2000);
    rand_out = 1'b0;

    // Abort after 4 of 12 beats: in-flight beats are dropped and no done is raised.
    set_cfg(3, 4, 0, 1, 0, 0, 0, 0);
    gen_model(3, 4, 4);
    d0 = done_cnt;
    start_layer();
    fork
      drive_acc(4, 0);
      drive_res(4, 0);
    join
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    exp_q.delete(); acc_q.delete(); res_q.delete();
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt - d0, 0);
    set_cfg(2, 3, 0, 1, 1, 0, 1, 1);
    gen_model(2, 3, 6);
    run_layer(6, 2, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bn_res_act_stage.md
BN_RES_ACT_STAGE -- requirements
Module: bn_res_act_stage

Interface
REQ-001 SHALL have parameter TOUT, default 8, output lanes per beat (one channel group).
REQ-002 SHALL have parameter ACC_DW, default 32, signed MVM accumulator width per lane.
REQ-003 SHALL have parameter DAT_DW, default 16, signed residual and output data width per lane.
REQ-004 SHALL have parameter BN_DW, default 16, signed BN weight and BN bias width.
REQ-005 SHALL have parameter MAX_GRP, default 64, depth of the BN parameter buffer in channel groups.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 start  in  1  one-cycle pulse; latches the config inputs and begins a layer.
REQ-010 cfg_ch_grp  in  16  number of channel groups, CHout_Padding/TOUT; 0 is illegal.
REQ-011 cfg_pix  in  16  pixels per channel group, Wout*Hout; 0 is illegal.
REQ-012 cfg_relu_en, cfg_res_en  in  1 each  enable ReLU; enable residual add.
REQ-013 cfg_wt_sh, cfg_bias_sh, cfg_res_sh, cfg_out_sh  in  5 each  arithmetic shift amounts.
REQ-014 bn_wr_en  in  1  BN parameter buffer write strobe.
REQ-015 bn_wr_addr  in  log2(MAX_GRP)  channel-group index to write.
REQ-016 bn_wr_data  in  2*BN_DW*TOUT  {bias,weight} per lane; lane 0 in the LSBs.
REQ-017 acc_valid, acc_ready  in/out  1  MVM accumulator stream handshake.
REQ-018 acc_data  in  ACC_DW*TOUT  accumulator lanes.
REQ-019 res_valid, res_ready  in/out  1  residual stream handshake.
REQ-020 res_data  in  DAT_DW*TOUT  residual lanes.
REQ-021 out_valid, out_ready  out/in  1  result stream handshake.
REQ-022 out_data  out  DAT_DW*TOUT  result lanes.
REQ-023 busy, done  out  1 each  layer in progress; one-cycle completion pulse.

Function
REQ-024 FSM SHALL have states IDLE, RUN and DRAIN; IDLE->RUN on start, RUN->DRAIN after the last input beat is accepted, DRAIN->IDLE when the pipeline is empty, with done pulsed for 1 cycle on that transition.
REQ-025 start SHALL be ignored outside IDLE; busy SHALL be 1 in RUN and DRAIN.
REQ-026 Input beat order SHALL be channel-group outer, pixel inner; pix_cnt wraps at cfg_pix-1 and then increments grp_cnt; the beat with grp_cnt=cfg_ch_grp-1 and pix_cnt=cfg_pix-1 is the last.
REQ-027 An input beat is accepted when state=RUN, adv=1, acc_valid=1, and (res_valid=1 or cfg_res_en=0).
REQ-028 acc_ready SHALL equal RUN & adv & (res_valid | ~cfg_res_en); res_ready SHALL equal RUN & adv & acc_valid & cfg_res_en. Both SHALL be combinational.
REQ-029 The pipeline SHALL have 3 stages. adv = ~(s3_valid & ~out_ready); all stages hold when adv=0. Latency from acceptance to out_valid is 3 cycles when out_ready=1.
REQ-030 Stage 1 SHALL read BN weight w and bias b at grp_cnt, and register acc and res.
REQ-031 Stage 2 SHALL compute p = (acc*w) >>> cfg_wt_sh, signed, 64-bit intermediate with arithmetic shift.
REQ-032 Stage 3 SHALL compute t = p + (b <<< cfg_bias_sh) + (cfg_res_en ? res <<< cfg_res_sh : 0), then r = t >>> cfg_out_sh.
REQ-033 Stage 3 SHALL set r to 0 if cfg_relu_en=1 and r<0, then saturate r to [-2^(DAT_DW-1), 2^(DAT_DW-1)-1].
REQ-034 Sustained throughput SHALL be 1 beat per cycle when acc, res and out are never stalled.
REQ-035 bn_wr_en writes SHALL be permitted in any state; a write to the group that stage 1 reads in the same cycle SHALL return the old value.
REQ-036 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-037 On rst: state=IDLE; pix_cnt, grp_cnt and all stage valids =0.
REQ-038 On rst: out_valid, busy, done, acc_ready and res_ready =0; out_data =0.
REQ-039 The BN parameter buffer SHALL NOT be cleared by rst.
REQ-040 rst asserted mid-layer SHALL discard all in-flight beats; no done pulse is generated.

Verification
REQ-041 TOUT=8, weights=1, bias=0, all shifts 0, res_en=0, relu=0, pix=1, grp=68; acc lane k=k-3 -> outputs equal the inputs, 68 beats, done once, 3-cycle latency.
REQ-042 w=3, b=2, wt_sh=1, bias_sh=2, res_en=1, res_sh=0, out_sh=1, acc=10, res=-4 -> (15+8-4)>>>1 = 9.
REQ-043 acc=-100, w=1, relu=1 -> 0; acc=40000, w=4, relu=0 -> 32767; acc=-40000, w=4 -> -32768.
REQ-044 out_ready toggled randomly, acc_valid/res_valid skewed by up to 5 cycles, grp=2, pix=3 -> in-order outputs, no loss or duplication, res_ready=0 throughout when res_en=0.
REQ-045 rst pulsed after 4 of 12 beats, then a new layer started -> stale beats never appear; the new layer completes correctly with BN parameters preserved.
